// File: rtl/multi_alarm_timekeeper.sv
// 24 h timekeeping core with NUM_ALARMS independent alarm channels, each with
// its own snooze and ring-timeout state machine, plus blink and buzzer outputs.
module multi_alarm_timekeeper #(
  parameter int unsigned CLK_HZ     = 31_500_000,
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned RING_SEC   = 600,
  parameter int unsigned TONE_HALF  = 5000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sec_inc,
  input  logic                  min_inc,
  input  logic                  hr_inc,
  input  logic [2:0]            al_sel,
  input  logic                  al_min_inc,
  input  logic                  al_hr_inc,
  input  logic                  al_toggle,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [4:0]            hours,
  output logic [3:0]            hours12,
  output logic [5:0]            minutes,
  output logic [5:0]            seconds,
  output logic                  sec_pulse,
  output logic                  half_sec,
  output logic [4:0]            al_hours_rd,
  output logic [5:0]            al_minutes_rd,
  output logic [NUM_ALARMS-1:0] al_enabled,
  output logic [NUM_ALARMS-1:0] al_ringing,
  output logic                  buzzer
);

  localparam int unsigned PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned TW      = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int unsigned CNT_MAX = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
  localparam int unsigned CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF  = PW'(CLK_HZ / 2);
  localparam logic [TW-1:0] TONE_MAX    = TW'(TONE_HALF - 1);
  localparam logic [CW-1:0] RING_LOAD   = CW'(RING_SEC);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SEC);

  typedef enum logic [1:0] {S_OFF, S_ARMED, S_RINGING, S_SNOOZE} state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic          sec_pulse_q, half_sec_q, tone_q, buzzer_q;
  logic [TW-1:0] tone_cnt_q;
  logic          wrap, carry_s, carry_m, sel_valid;

  logic [4:0]    al_h_q [NUM_ALARMS];
  logic [4:0]    al_h_d [NUM_ALARMS];
  logic [5:0]    al_m_q [NUM_ALARMS];
  logic [5:0]    al_m_d [NUM_ALARMS];
  state_e        state_q [NUM_ALARMS];
  state_e        state_d [NUM_ALARMS];
  logic [CW-1:0] cnt_q [NUM_ALARMS];
  logic [CW-1:0] cnt_d [NUM_ALARMS];

  // A tick and a manual adjust hitting the same field collapse into one increment.
  always_comb begin
    wrap    = (presc_q == PRESC_MAX);
    carry_s = wrap && (sec_q == 6'd59);
    carry_m = carry_s && (min_q == 6'd59);
    presc_d = (wrap || sec_inc) ? '0 : presc_q + PW'(1);
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    if (wrap || sec_inc)   sec_d = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
    if (carry_s || min_inc) min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
    if (carry_m || hr_inc)  hr_d  = (hr_q == 5'd23) ? '0 : hr_q + 5'd1;
  end

  always_comb begin
    sel_valid = (32'(al_sel) < NUM_ALARMS);
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      al_h_d[i]  = al_h_q[i];
      al_m_d[i]  = al_m_q[i];
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (sel_valid && (32'(al_sel) == i)) begin
        if (al_min_inc) al_m_d[i] = (al_m_q[i] == 6'd59) ? '0 : al_m_q[i] + 6'd1;
        if (al_hr_inc)  al_h_d[i] = (al_h_q[i] == 5'd23) ? '0 : al_h_q[i] + 5'd1;
      end
      if (sel_valid && (32'(al_sel) == i) && al_toggle) begin
        state_d[i] = (state_q[i] == S_OFF) ? S_ARMED : S_OFF;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          S_ARMED: begin
            if (sec_pulse_q && (hr_q == al_h_q[i]) && (min_q == al_m_q[i]) && (sec_q == 6'd0)) begin
              state_d[i] = S_RINGING;
              cnt_d[i]   = RING_LOAD;
            end
          end
          S_RINGING: begin
            if (dismiss) begin
              state_d[i] = S_ARMED;
              cnt_d[i]   = '0;
            end else if (snooze) begin
              state_d[i] = S_SNOOZE;
              cnt_d[i]   = SNOOZE_LOAD;
            end else if (sec_pulse_q) begin
              if (cnt_q[i] <= CW'(1)) begin
                state_d[i] = S_ARMED;
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i] = cnt_q[i] - CW'(1);
              end
            end
          end
          S_SNOOZE: begin
            if (dismiss) begin
              state_d[i] = S_ARMED;
              cnt_d[i]   = '0;
            end else if (sec_pulse_q) begin
              if (cnt_q[i] <= CW'(1)) begin
                state_d[i] = S_RINGING;
                cnt_d[i]   = RING_LOAD;
              end else begin
                cnt_d[i] = cnt_q[i] - CW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hr_q        <= '0;
      sec_pulse_q <= 1'b0;
      half_sec_q  <= 1'b0;
      tone_cnt_q  <= '0;
      tone_q      <= 1'b0;
      buzzer_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        al_h_q[i]  <= '0;
        al_m_q[i]  <= '0;
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      sec_pulse_q <= wrap;
      half_sec_q  <= (presc_d >= PRESC_HALF);
      if (tone_cnt_q == TONE_MAX) begin
        tone_cnt_q <= '0;
        tone_q     <= ~tone_q;
      end else begin
        tone_cnt_q <= tone_cnt_q + TW'(1);
      end
      buzzer_q <= (|al_ringing) & half_sec_q & tone_q;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        al_h_q[i]  <= al_h_d[i];
        al_m_q[i]  <= al_m_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    al_hours_rd   = '0;
    al_minutes_rd = '0;
    al_enabled    = '0;
    al_ringing    = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      al_enabled[i] = (state_q[i] != S_OFF);
      al_ringing[i] = (state_q[i] == S_RINGING);
      if (sel_valid && (32'(al_sel) == i)) begin
        al_hours_rd   = al_h_q[i];
        al_minutes_rd = al_m_q[i];
      end
    end
  end

  assign hours     = hr_q;
  assign hours12   = (hr_q >= 5'd12) ? 4'(hr_q - 5'd12) : hr_q[3:0];
  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign sec_pulse = sec_pulse_q;
  assign half_sec  = half_sec_q;
  assign buzzer    = buzzer_q;

endmodule
